// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack CPU with separate request/ready instruction
// and data memory ports. Each instruction runs FETCH -> [MEM_RD] -> EXEC ->
// [MEM_WR]. Only one memory request is ever active, because every request
// is tied to exactly one state.
module hack_cpu_mc #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 15,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0]      imem_rdata,
  input  logic                  imem_ready,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0]      dmem_wdata,
  input  logic [WIDTH-1:0]      dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  retire,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [ADDR_WIDTH-1:0] L_RESET_PC = ADDR_WIDTH'(RESET_PC);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_MEM_RD = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_MEM_WR = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_d;
  logic [WIDTH-1:0]      r_ir;
  logic [WIDTH-1:0]      r_mdr;
  logic [WIDTH-1:0]      r_wdata;
  // r_waddr doubles as the jump target. Both are the pre-update A.
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_jumpTaken;

  // Instruction fields
  logic                  w_isC;
  logic                  w_aBit;
  logic [5:0]            w_comp;
  logic [2:0]            w_dest;
  logic [2:0]            w_jmp;
  logic [ADDR_WIDTH-1:0] w_aAddr;
  logic [ADDR_WIDTH-1:0] w_pcInc;

  // ALU datapath
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_x0;
  logic [WIDTH-1:0] w_x1;
  logic [WIDTH-1:0] w_y0;
  logic [WIDTH-1:0] w_y1;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_alu;
  logic             w_ng;
  logic             w_zr;
  logic             w_jump;

  assign w_isC   = r_ir[WIDTH-1];
  assign w_aBit  = r_ir[12];
  assign w_comp  = r_ir[11:6];
  assign w_dest  = r_ir[5:3];
  assign w_jmp   = r_ir[2:0];
  assign w_aAddr = r_a[ADDR_WIDTH-1:0];
  // pc+1 wraps naturally at the ADDR_WIDTH boundary.
  assign w_pcInc = r_pc + 1'b1;

  // Hack ALU: the zx/nx/zy/ny/f/no control bits are taken directly from comp.
  assign w_y    = w_aBit ? r_mdr : r_a;
  assign w_x0   = w_comp[5] ? '0 : r_d;
  assign w_x1   = w_comp[4] ? ~w_x0 : w_x0;
  assign w_y0   = w_comp[3] ? '0 : w_y;
  assign w_y1   = w_comp[2] ? ~w_y0 : w_y0;
  assign w_f    = w_comp[1] ? (w_x1 + w_y1) : (w_x1 & w_y1);
  assign w_alu  = w_comp[0] ? ~w_f : w_f;
  assign w_ng   = w_alu[WIDTH-1];
  assign w_zr   = (w_alu == '0);
  // jump bits: [2] less than zero, [1] equal to zero, [0] greater than zero.
  assign w_jump = (w_jmp[2] & w_ng) | (w_jmp[1] & w_zr) | (w_jmp[0] & ~w_ng & ~w_zr);

  // Memory requests follow the state directly.
  // imem_req is also gated by reset_n so that it is low while reset is held.
  assign imem_req   = reset_n && (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign dmem_we    = (r_state == S_MEM_WR);
  assign dmem_addr  = (r_state == S_MEM_WR) ? r_waddr : w_aAddr;
  assign dmem_wdata = r_wdata;
  assign pc         = r_pc;
  assign retire     = ((r_state == S_EXEC) && (!w_isC || !w_dest[0])) ||
                      ((r_state == S_MEM_WR) && dmem_ready);

  // Instruction sequencer and architectural state.
  // Async reset discards any in-flight instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_FETCH;
      r_pc        <= L_RESET_PC;
      r_a         <= '0;
      r_d         <= '0;
      r_ir        <= '0;
      r_mdr       <= '0;
      r_wdata     <= '0;
      r_waddr     <= '0;
      r_jumpTaken <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_ir    <= imem_rdata;
            r_state <= (imem_rdata[WIDTH-1] && imem_rdata[12]) ? S_MEM_RD : S_EXEC;
          end
        end
        S_MEM_RD: begin
          if (dmem_ready) begin
            r_mdr   <= dmem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!w_isC) begin
            r_a     <= r_ir;
            r_pc    <= w_pcInc;
            r_state <= S_FETCH;
          end else begin
            if (w_dest[1]) r_d <= w_alu;
            if (w_dest[2]) r_a <= w_alu;
            if (w_dest[0]) begin
              // The write target and the jump outcome are captured here.
              // A may be overwritten in this same cycle, so they cannot be read later.
              r_wdata     <= w_alu;
              r_waddr     <= w_aAddr;
              r_jumpTaken <= w_jump;
              r_state     <= S_MEM_WR;
            end else begin
              r_pc    <= w_jump ? w_aAddr : w_pcInc;
              r_state <= S_FETCH;
            end
          end
        end
        S_MEM_WR: begin
          if (dmem_ready) begin
            r_pc    <= r_jumpTaken ? r_waddr : w_pcInc;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
